// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types for the instruction prefetch queue.
package ifq_pkg;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifq_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular-buffer FIFO of fetched {pc, instr} entries; clear wins over push.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  ifq_entry_t               din,
    output ifq_entry_t               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    ifq_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign full = count[AW];
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push && !clear)
            mem[wr_ptr] <= din;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-limited instruction prefetch queue with redirect flush and drain.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] INITIAL_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [13:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    input  logic        instr_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    ifq_state_e state;
    ifq_state_e state_next;
    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic [31:0] redirect_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] fifo_count;
    logic grant;
    logic rsp;
    logic push;
    logic pop;
    logic full;
    logic empty;
    ifq_entry_t din;
    ifq_entry_t head;
    assign redirect_pc = redirect_pc_i & ~32'd3;
    // Credits count both buffered and outstanding words, so every response has a slot.
    assign imem_req_o = (state == FETCH) && !redirect_i && (int'(fifo_count) + int'(inflight) < DEPTH);
    assign imem_addr_o = fetch_pc[15:2];
    assign grant = imem_req_o && imem_gnt_i;
    assign rsp = imem_rvalid_i && (inflight != '0);
    assign push = rsp && (state == FETCH) && !redirect_i && !full;
    assign pop = instr_valid_o && instr_ready_i;
    assign inflight_next = inflight + CW'(grant) - CW'(rsp);
    assign din = '{pc: resp_pc, instr: imem_rdata_i};
    always_comb
        state_next = redirect_i ? (inflight_next != '0 ? DRAIN : FETCH)
                   : state == BOOT ? FETCH
                   : (state == DRAIN && inflight_next == '0) ? FETCH : state;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= BOOT;
            fetch_pc <= INITIAL_PC;
            resp_pc <= INITIAL_PC;
            inflight <= '0;
        end else begin
            state <= state_next;
            inflight <= inflight_next;
            fetch_pc <= redirect_i ? redirect_pc : grant ? fetch_pc + 32'd4 : fetch_pc;
            resp_pc <= redirect_i ? redirect_pc : push ? resp_pc + 32'd4 : resp_pc;
        end
    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect_i),
        .din   (din),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
    assign instr_valid_o = !empty;
    assign instr_o = empty ? '0 : head.instr;
    assign pc_o = empty ? '0 : head.pc;
    assign pc4_o = pc_o + 32'd4;
    // A response with nothing outstanding breaks the memory protocol; it is ignored above.
    rsp_without_request: assert property (@(posedge clk) disable iff (rst) imem_rvalid_i |-> inflight != '0);
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and randomized checks of the prefetch queue against a memory and PC-stream model.
module tb_ifetch_queue;
    import ifq_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic rst = 1;
    logic redirect_i = 0;
    logic [31:0] redirect_pc_i = 0;
    logic imem_req_o;
    logic [13:0] imem_addr_o;
    logic imem_gnt_i = 0;
    logic imem_rvalid_i = 0;
    logic [31:0] imem_rdata_i = 0;
    logic instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic instr_ready_i = 0;
    always #5 clk = ~clk;
    ifetch_queue #(.DEPTH(DEPTH), .INITIAL_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .instr_ready_i (instr_ready_i)
    );
    typedef struct {
        logic [13:0] addr;
        int          due;
    } req_t;
    req_t pending[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_due = 0;
    int lat_min = 1;
    int lat_max = 1;
    int gnt_mode = 1;
    int rdy_mode = 1;
    int grants = 0;
    logic prev_redirect = 0;
    logic [31:0] exp_pc = 0;
    function automatic logic [31:0] word(input logic [13:0] a);
        return {a, 4'hC, a};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    // Drive memory/consumer inputs for this cycle, then let combinational outputs settle.
    task automatic settle();
        imem_gnt_i = gnt_mode == 2 ? ($urandom_range(0, 1) == 1) : (gnt_mode == 1);
        instr_ready_i = rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        imem_rvalid_i = 0;
        imem_rdata_i = 0;
        if (pending.size() != 0)
            if (pending[0].due <= cyc) begin
                imem_rvalid_i = 1;
                imem_rdata_i = word(pending[0].addr);
            end
        #1;
    endtask
    task automatic tick();
        logic g;
        logic rv;
        logic [13:0] a;
        int d;
        g = imem_req_o && imem_gnt_i;
        rv = imem_rvalid_i;
        a = imem_addr_o;
        if (prev_redirect)
            chk1("valid_after_redirect", instr_valid_o, 1'b0);
        if (redirect_i)
            chk1("req_masked", imem_req_o, 1'b0);
        if (instr_valid_o && instr_ready_i) begin
            chk("pop_pc", pc_o, exp_pc);
            chk("pop_instr", instr_o, word(pc_o[15:2]));
            chk("pop_pc4", pc4_o, pc_o + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_i)
            exp_pc = redirect_pc_i & ~32'd3;
        prev_redirect = redirect_i;
        chk1("credit", (int'(dut.fifo_count) + int'(dut.inflight)) <= DEPTH, 1'b1);
        @(posedge clk);
        if (g) begin
            d = cyc + int'($urandom_range(lat_min, lat_max));
            last_due = d > last_due + 1 ? d : last_due + 1;
            pending.push_back('{a, last_due});
            grants++;
        end
        if (rv)
            void'(pending.pop_front());
        cyc++;
        @(negedge clk);
    endtask
    task automatic step();
        settle();
        tick();
    endtask
    task automatic do_reset();
        rst = 1;
        redirect_i = 0;
        imem_rvalid_i = 0;
        imem_gnt_i = 0;
        pending.delete();
        repeat (2) @(negedge clk);
        chk1("rst_req", imem_req_o, 1'b0);
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc4_o, 32'h4);
        exp_pc = 0;
        last_due = cyc;
        prev_redirect = 0;
        rst = 0;
    endtask
    task automatic expect_first(input string tag, input logic [31:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (instr_valid_o) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk1({tag, "_seen"}, seen, 1'b1);
        if (seen) begin
            chk(tag, pc_o, exp);
            tick();
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        // Grant every cycle, latency 1, consumer always ready.
        do_reset();
        settle(); chk1("s1_boot_req", imem_req_o, 1'b0); tick();
        settle(); chk1("s1_req", imem_req_o, 1'b1); chk("s1_addr0", 32'(imem_addr_o), 0); tick();
        settle(); chk("s1_addr1", 32'(imem_addr_o), 1); chk1("s1_no_bypass", instr_valid_o, 1'b0); tick();
        settle(); chk1("s1_valid", instr_valid_o, 1'b1); chk("s1_pc0", pc_o, 32'h0); tick();
        settle(); chk("s1_pc1", pc_o, 32'h4); tick();
        settle(); chk("s1_pc2", pc_o, 32'h8); tick();
        // Consumer stalled: only DEPTH credits worth of grants.
        rdy_mode = 0;
        do_reset();
        grants = 0;
        repeat (11) step();
        rdy_mode = 1;
        settle(); chk("s2_grants", grants, 4); chk1("s2_req_low", imem_req_o, 1'b0); chk("s2_pc0", pc_o, 32'h0); tick();
        settle(); chk("s2_pc1", pc_o, 32'h4); tick();
        settle(); chk("s2_pc2", pc_o, 32'h8); tick();
        settle(); chk("s2_pc3", pc_o, 32'hC); tick();
        // Redirect with three requests in flight at latency 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (4) step();
        redirect_i = 1; redirect_pc_i = 32'h100;
        settle(); chk1("s3_req_masked", imem_req_o, 1'b0); tick();
        redirect_i = 0;
        settle(); chk("s3_state", 32'(dut.state), 32'(DRAIN)); chk1("s3_drain_req", imem_req_o, 1'b0); tick();
        settle(); chk1("s3_drain_req2", imem_req_o, 1'b0); tick();
        settle(); chk1("s3_restart_req", imem_req_o, 1'b1); chk("s3_restart_addr", 32'(imem_addr_o), 32'h40); tick();
        expect_first("s3_first_pc", 32'h100);
        // Redirect coinciding with a response and a pop; low address bits are dropped.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) step();
        redirect_i = 1; redirect_pc_i = 32'h203;
        settle(); chk1("s4_pop_valid", instr_valid_o, 1'b1); tick();
        redirect_i = 0;
        settle(); chk1("s4_req", imem_req_o, 1'b1); chk("s4_addr", 32'(imem_addr_o), 32'h80); tick();
        expect_first("s4_first_pc", 32'h200);
        // Random grants, latencies and stalls with periodic redirects, including a PC wrap.
        gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 3) begin
                redirect_i = 1;
                redirect_pc_i = 32'hFFFF_FFF9;
            end else if (i % 23 == 7) begin
                redirect_i = 1;
                redirect_pc_i = $urandom;
            end
            step();
            redirect_i = 0;
        end
        // Asynchronous reset in the middle of a drain.
        gnt_mode = 1; rdy_mode = 1; lat_min = 3; lat_max = 3;
        do_reset();
        repeat (4) step();
        redirect_i = 1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 0;
        settle();
        chk("s6_state_drain", 32'(dut.state), 32'(DRAIN));
        rst = 1;
        imem_rvalid_i = 0;
        imem_gnt_i = 0;
        pending.delete();
        #1;
        chk("s6_state_boot", 32'(dut.state), 32'(BOOT));
        chk1("s6_req", imem_req_o, 1'b0);
        chk1("s6_valid", instr_valid_o, 1'b0);
        chk("s6_pc", pc_o, 32'h0);
        chk("s6_pc4", pc4_o, 32'h4);
        @(negedge clk);
        exp_pc = 0;
        last_due = cyc;
        prev_redirect = 0;
        rst = 0;
        settle(); chk1("s6_boot_req", imem_req_o, 1'b0); tick();
        settle(); chk1("s6_req_after", imem_req_o, 1'b1); chk("s6_addr_after", 32'(imem_addr_o), 0); tick();
        expect_first("s6_first_pc", 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
